pseudo_spi_in_intf: RTL and testbench
=====================================

# pseudo_spi_in_intf

Serial capture interface for the analog device scan chain. It pulses SEL and the two-phase clocks SCLK1/SCLK2 to load and shift the device's internal chain. It samples the returned serial bit stream on SPI_SI and assembles it into MEMORY_DATA_WIDTH-bit words. Each word is written to SRAM at descending addresses starting at ADDR_BGN, for DATA_LEN words, which makes this block the read-back counterpart to the CPU's pseudo-SPI output path.

## Interface
- MEMORY_DATA_WIDTH, 8, SRAM word width and bits per captured word
- MEMORY_ADDR_WIDTH, 9, SRAM address width
- RESERVED_DATA_LEN, 8, width of DATA_LEN
- CLK  input  1  system clock; all logic on posedge
- BGN  input  1  synchronous active-low reset; high = run one transfer
- ADDR_BGN  input  MEMORY_ADDR_WIDTH  first SRAM write address
- DATA_LEN  input  RESERVED_DATA_LEN  number of words to capture
- FREQ_DIV  input  8  phase length minus one
- SPI_SI  input  1  serial data from device
- SCLK1  output  1  phase-1 shift clock
- SCLK2  output  1  phase-2 shift clock
- SEL  output  1  device parallel-load select
- A  output  MEMORY_ADDR_WIDTH  SRAM address; 0 whenever CEN=1
- D  output  MEMORY_DATA_WIDTH  SRAM write data
- CEN  output  1  SRAM chip enable, low active
- D_WE  output  1  SRAM write enable, low = write
- spi_is_done  output  1  transfer complete

## Operation
- Reset values while BGN=0:
  - outputs: SCLK1=0, SCLK2=0, SEL=0, CEN=1, D_WE=1, A=0, D=0, spi_is_done=0.
  - FSM is in IDLE.
  - ADDR_BGN, DATA_LEN and FREQ_DIV are captured every cycle; input changes while BGN=1 are ignored.
- FSM states: IDLE, LOAD, SAMP, PH1, GAP1, PH2, GAP2, WRITE, DONE.
- IDLE: first edge with BGN=1 → LOAD, or → DONE if DATA_LEN=0.
- LOAD:
  - SEL=1 throughout.
  - Internally sequences PH1/GAP1/PH2/GAP2 with SCLK1 and SCLK2 pulsed as in the shift phases.
  - Then → SAMP.
- SAMP (1 cycle): SPI_SI is shifted into the word register LSB-first: the first sampled bit lands in D bit 0 after assembly.
- Shift phases:
  - Each of PH1, GAP1, PH2 and GAP2 lasts FREQ_DIV+1 cycles, timed by a down-counter reloaded on each phase entry.
  - SCLK1=1 only in PH1; SCLK2=1 only in PH2; never both high.
- After GAP2:
  - → SAMP if bits remain in the word.
  - Otherwise → WRITE.
  - Every bit, including the last of each word, gets a full SCLK1/SCLK2 pulse so the chain presents the next bit.
- WRITE (1 cycle):
  - CEN=0, D_WE=0; A = current address, D = assembled word.
  - Address decrements modulo 2^MEMORY_ADDR_WIDTH (0 wraps to all-ones); word count decrements.
  - Then → SAMP if words remain, else → DONE.
- DONE: spi_is_done=1, all strobes idle; held until BGN=0.
- All outputs are driven from flops; no combinational glitches on SCLK1, SCLK2, SEL or CEN.

## Timing
- Let F=FREQ_DIV and N=DATA_LEN. Edge 1 is the first rising CLK edge with BGN=1.
- LOAD is entered at edge 1 and spans 4(F+1) cycles.
- Each word takes 8·(4F+5)+1 cycles for MEMORY_DATA_WIDTH=8.
- spi_is_done rises at edge 1+4(F+1)+N·(8(4F+5)+1); for N=0 it rises at edge 1.
- CEN and D_WE are low for exactly one cycle per word, with A and D stable during that cycle.
- BGN=0 mid-transfer:
  - all outputs take reset values at the next edge;
  - a partial word is discarded and never written;
  - a new transfer starts cleanly on the next BGN rise.

## Configuration
- PSEUDO_SPI_IN_MSB_FIRST_EN defined: words are assembled MSB-first, so the first sampled bit lands in D[MEMORY_DATA_WIDTH-1].
- Undefined (default): LSB-first, matching the output path's bit order.
- Cycle timing is identical in both cases.

## Test plan
- F=0, N=1, ADDR_BGN=0x010, device returns 0xA5 LSB-first → single write D=0xA5, A=0x010; spi_is_done at edge 46; SCLK1 and SCLK2 each pulse 9 times.
- F=2, N=3, ADDR_BGN=0x002, words 0x11/0x22/0x33 → writes 0x11@0x002, 0x22@0x001, 0x33@0x000; SCLK1 width 3 cycles; done at edge 328.
- ADDR_BGN=0x000, N=2, F=0 → writes at 0x000 then 0x1FF; A=0 whenever CEN=1.
- DATA_LEN=0 → spi_is_done at edge 1; SEL, SCLK1 and SCLK2 never pulse; CEN stays 1.
- F=0, N=3, BGN dropped during bit 5 of word 2 → next edge all outputs reset, only word 1 written; rerun with N=1 completes normally at edge 46.
- PSEUDO_SPI_IN_MSB_FIRST_EN defined, F=0, N=1, serial stream 1,0,0,0,0,0,0,0 → D=0x80 (0x01 when undefined).

Source files
------------

// File: rtl/pseudo_spi_in_intf.sv
// Serial capture from the analog scan chain into SRAM at descending addresses.
// Define PSEUDO_SPI_IN_MSB_FIRST_EN to assemble words MSB-first (default LSB-first).
module pseudo_spi_in_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic [7:0]                   FREQ_DIV,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         CEN,
  output logic                         D_WE,
  output logic                         spi_is_done
);

  localparam int BW = $clog2(MEMORY_DATA_WIDTH + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    SAMP  = 4'd2,
    PH1   = 4'd3,
    GAP1  = 4'd4,
    PH2   = 4'd5,
    GAP2  = 4'd6,
    WRITE = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t                       state, next_state;
  logic [1:0]                   sub, sub_n;
  logic [7:0]                   cnt, cnt_n;
  logic [7:0]                   freq;
  logic [BW-1:0]                bits, bits_n;
  logic [RESERVED_DATA_LEN-1:0] words, words_n;
  logic [MEMORY_ADDR_WIDTH-1:0] addr, addr_n;
  logic [MEMORY_DATA_WIDTH-1:0] word, word_n;

  logic                         sclk1_n, sclk2_n, sel_n, cen_n, done_n;
  logic [MEMORY_ADDR_WIDTH-1:0] a_n;
  logic [MEMORY_DATA_WIDTH-1:0] d_n;

  // State, datapath and output registers; BGN low also captures the job parameters
  always_ff @(posedge CLK) begin
    if (!BGN) begin
      state       <= IDLE;
      sub         <= 2'd0;
      cnt         <= 8'd0;
      bits        <= '0;
      word        <= '0;
      freq        <= FREQ_DIV;
      words       <= DATA_LEN;
      addr        <= ADDR_BGN;
      SCLK1       <= 1'b0;
      SCLK2       <= 1'b0;
      SEL         <= 1'b0;
      CEN         <= 1'b1;
      D_WE        <= 1'b1;
      A           <= '0;
      D           <= '0;
      spi_is_done <= 1'b0;
    end else begin
      state       <= next_state;
      sub         <= sub_n;
      cnt         <= cnt_n;
      bits        <= bits_n;
      word        <= word_n;
      freq        <= freq;
      words       <= words_n;
      addr        <= addr_n;
      SCLK1       <= sclk1_n;
      SCLK2       <= sclk2_n;
      SEL         <= sel_n;
      CEN         <= cen_n;
      D_WE        <= cen_n;
      A           <= a_n;
      D           <= d_n;
      spi_is_done <= done_n;
    end
  end

  // Next-state and datapath update; each timed phase reloads the down-counter on entry
  always_comb begin
    next_state = state;
    sub_n      = sub;
    cnt_n      = cnt;
    bits_n     = bits;
    words_n    = words;
    addr_n     = addr;
    word_n     = word;
    case (state)
      IDLE: begin
        sub_n  = 2'd0;
        cnt_n  = freq;
        bits_n = '0;
        if (words == '0) next_state = DONE;
        else             next_state = LOAD;
      end
      LOAD: begin
        if (cnt == 8'd0) begin
          cnt_n = freq;
          if (sub == 2'd3) next_state = SAMP;
          else             sub_n = sub + 2'd1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      SAMP: begin
        next_state = PH1;
        cnt_n      = freq;
        bits_n     = bits + {{(BW-1){1'b0}}, 1'b1};
`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
        word_n     = {word[MEMORY_DATA_WIDTH-2:0], SPI_SI};
`else
        word_n     = {SPI_SI, word[MEMORY_DATA_WIDTH-1:1]};
`endif
      end
      PH1, GAP1, PH2: begin
        if (cnt == 8'd0) begin
          cnt_n = freq;
          if (state == PH1)       next_state = GAP1;
          else if (state == GAP1) next_state = PH2;
          else                    next_state = GAP2;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP2: begin
        if (cnt == 8'd0) begin
          cnt_n = freq;
          if (bits == BW'(MEMORY_DATA_WIDTH)) next_state = WRITE;
          else                                next_state = SAMP;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      WRITE: begin
        bits_n  = '0;
        words_n = words - {{(RESERVED_DATA_LEN-1){1'b0}}, 1'b1};
        addr_n  = addr - {{(MEMORY_ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (words == {{(RESERVED_DATA_LEN-1){1'b0}}, 1'b1}) next_state = DONE;
        else                                                next_state = SAMP;
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the pins come straight off flops
  always_comb begin
    sclk1_n = (next_state == PH1) || ((next_state == LOAD) && (sub_n == 2'd0));
    sclk2_n = (next_state == PH2) || ((next_state == LOAD) && (sub_n == 2'd2));
    sel_n   = (next_state == LOAD);
    cen_n   = (next_state != WRITE);
    done_n  = (next_state == DONE);
    if (next_state == WRITE) begin
      a_n = addr;
      d_n = word;
    end else begin
      a_n = '0;
      d_n = '0;
    end
  end

endmodule

// File: tb/tb_pseudo_spi_in_intf.sv
// Directed bench for pseudo_spi_in_intf with a behavioural scan-chain device model.
module tb_pseudo_spi_in_intf;

  logic       CLK;
  logic       BGN;
  logic [8:0] ADDR_BGN;
  logic [7:0] DATA_LEN;
  logic [7:0] FREQ_DIV;
  logic       SPI_SI;
  logic       SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done;
  logic [8:0] A;
  logic [7:0] D;

  int tests;
  int failed;

  logic [7:0] dev_words [0:7];
  int         dev_k;
  logic       dev_p2;

  int         n_wr;
  logic [8:0] wr_a [0:15];
  logic [7:0] wr_d [0:15];
  int         s1_rises, s2_rises, sel_rises, s1_max_w, s1_cur_w;
  int         cen_run, cen_max_run, a_bad, we_bad, both_hi, done_edge;

  pseudo_spi_in_intf dut (
    .CLK(CLK), .BGN(BGN), .ADDR_BGN(ADDR_BGN), .DATA_LEN(DATA_LEN),
    .FREQ_DIV(FREQ_DIV), .SPI_SI(SPI_SI), .SCLK1(SCLK1), .SCLK2(SCLK2),
    .SEL(SEL), .A(A), .D(D), .CEN(CEN), .D_WE(D_WE), .spi_is_done(spi_is_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Device: SCLK2 with SEL parallel-loads (bit 0 presented), SCLK2 alone advances one bit
  initial begin
    dev_k  = 0;
    dev_p2 = 1'b0;
    SPI_SI = 1'b0;
    forever begin
      @(negedge CLK);
      if (SCLK2 && !dev_p2) begin
        if (SEL) dev_k = 0;
        else     dev_k = dev_k + 1;
      end
      dev_p2 = SCLK2;
      if (dev_k < 64) SPI_SI = dev_words[dev_k / 8][dev_k % 8];
      else            SPI_SI = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_strobes"}, {26'd0, SCLK1, SCLK2, SEL, CEN, D_WE, spi_is_done}, 32'b000110);
    chk({tag, "_A"}, {23'd0, A}, 32'd0);
    chk({tag, "_D"}, {24'd0, D}, 32'd0);
  endtask

  // Holds BGN low two cycles with the job set up, then runs until done or max_edges
  task automatic run_xfer(input logic [8:0] addr, input logic [7:0] len,
                          input logic [7:0] f, input int max_edges);
    logic p1, p2, ps;
    BGN = 1'b0; ADDR_BGN = addr; DATA_LEN = len; FREQ_DIV = f;
    repeat (2) @(negedge CLK);
    n_wr = 0; s1_rises = 0; s2_rises = 0; sel_rises = 0; s1_max_w = 0; s1_cur_w = 0;
    cen_run = 0; cen_max_run = 0; a_bad = 0; we_bad = 0; both_hi = 0; done_edge = -1;
    p1 = 1'b0; p2 = 1'b0; ps = 1'b0;
    BGN = 1'b1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (SCLK1 && !p1) s1_rises++;
      if (SCLK2 && !p2) s2_rises++;
      if (SEL && !ps) sel_rises++;
      if (SCLK1) s1_cur_w++; else s1_cur_w = 0;
      if (s1_cur_w > s1_max_w) s1_max_w = s1_cur_w;
      p1 = SCLK1; p2 = SCLK2; ps = SEL;
      if (SCLK1 && SCLK2) both_hi++;
      if (D_WE !== CEN) we_bad++;
      if (CEN === 1'b0) begin
        if (n_wr < 16) begin wr_a[n_wr] = A; wr_d[n_wr] = D; end
        n_wr++;
        cen_run++;
        if (cen_run > cen_max_run) cen_max_run = cen_run;
      end else begin
        cen_run = 0;
        if (A !== 9'd0) a_bad++;
      end
      if (spi_is_done === 1'b1 && done_edge < 0) done_edge = e;
      if (done_edge >= 0) break;
    end
  endtask

  task automatic chk_hygiene(input string tag);
    chk({tag, "_both_sclk"}, both_hi, 32'd0);
    chk({tag, "_we_eq_cen"}, we_bad, 32'd0);
    chk({tag, "_a_idle_zero"}, a_bad, 32'd0);
  endtask

  initial begin
    tests = 0; failed = 0;
    for (int i = 0; i < 8; i++) dev_words[i] = 8'h00;
    BGN = 1'b0; ADDR_BGN = 9'd0; DATA_LEN = 8'd0; FREQ_DIV = 8'd0;
    repeat (3) @(negedge CLK);
    chk_reset("reset");

    // F=0, N=1, 0xA5 at 0x010
    dev_words[0] = 8'hA5;
    run_xfer(9'h010, 8'd1, 8'd0, 200);
    chk("t1_done_edge", done_edge, 32'd46);
    chk("t1_nwr", n_wr, 32'd1);
    chk("t1_a", {23'd0, wr_a[0]}, 32'h010);
    chk("t1_d", {24'd0, wr_d[0]}, 32'hA5);
    chk("t1_sclk1_pulses", s1_rises, 32'd9);
    chk("t1_sclk2_pulses", s2_rises, 32'd9);
    chk("t1_cen_width", cen_max_run, 32'd1);
    chk_hygiene("t1");
    @(negedge CLK);
    chk("t1_done_held", {31'd0, spi_is_done}, 32'd1);

    // F=2, N=3, 0x11/0x22/0x33 from 0x002 downward
    dev_words[0] = 8'h11; dev_words[1] = 8'h22; dev_words[2] = 8'h33;
    run_xfer(9'h002, 8'd3, 8'd2, 1000);
    chk("t2_done_edge", done_edge, 32'd328);
    chk("t2_nwr", n_wr, 32'd3);
    chk("t2_w0", {14'd0, wr_a[0], 1'b0, wr_d[0]}, {14'd0, 9'h002, 1'b0, 8'h11});
    chk("t2_w1", {14'd0, wr_a[1], 1'b0, wr_d[1]}, {14'd0, 9'h001, 1'b0, 8'h22});
    chk("t2_w2", {14'd0, wr_a[2], 1'b0, wr_d[2]}, {14'd0, 9'h000, 1'b0, 8'h33});
    chk("t2_sclk1_width", s1_max_w, 32'd3);
    chk("t2_cen_width", cen_max_run, 32'd1);
    chk_hygiene("t2");

    // Address wrap from 0x000 to 0x1FF
    dev_words[0] = 8'h5C; dev_words[1] = 8'hE7;
    run_xfer(9'h000, 8'd2, 8'd0, 300);
    chk("t3_done_edge", done_edge, 32'd87);
    chk("t3_nwr", n_wr, 32'd2);
    chk("t3_w0", {14'd0, wr_a[0], 1'b0, wr_d[0]}, {14'd0, 9'h000, 1'b0, 8'h5C});
    chk("t3_w1", {14'd0, wr_a[1], 1'b0, wr_d[1]}, {14'd0, 9'h1FF, 1'b0, 8'hE7});
    chk_hygiene("t3");

    // DATA_LEN=0 finishes at the first edge without touching the device or SRAM
    run_xfer(9'h055, 8'd0, 8'd3, 20);
    chk("t4_done_edge", done_edge, 32'd1);
    chk("t4_sel", sel_rises, 32'd0);
    chk("t4_sclk", s1_rises + s2_rises, 32'd0);
    chk("t4_nwr", n_wr, 32'd0);

    // Abort inside the fifth bit of the second word
    dev_words[0] = 8'h3C; dev_words[1] = 8'hC3; dev_words[2] = 8'h5A;
    run_xfer(9'h040, 8'd3, 8'd0, 68);
    chk("t5_not_done", done_edge, 32'hFFFF_FFFF);
    BGN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset("t5_abort");
    chk("t5_nwr", n_wr, 32'd1);
    chk("t5_w0", {14'd0, wr_a[0], 1'b0, wr_d[0]}, {14'd0, 9'h040, 1'b0, 8'h3C});
    repeat (5) @(negedge CLK);
    chk("t5_no_late_write", {31'd0, CEN}, 32'd1);
    dev_words[0] = 8'h96;
    run_xfer(9'h020, 8'd1, 8'd0, 200);
    chk("t5_rerun_done", done_edge, 32'd46);
    chk("t5_rerun_nwr", n_wr, 32'd1);
    chk("t5_rerun_w0", {14'd0, wr_a[0], 1'b0, wr_d[0]}, {14'd0, 9'h020, 1'b0, 8'h96});

    // Bit order: stream 1,0,0,0,0,0,0,0
    dev_words[0] = 8'h01;
    run_xfer(9'h100, 8'd1, 8'd0, 200);
    chk("t6_nwr", n_wr, 32'd1);
`ifdef PSEUDO_SPI_IN_MSB_FIRST_EN
    chk("t6_bit_order", {24'd0, wr_d[0]}, 32'h80);
`else
    chk("t6_bit_order", {24'd0, wr_d[0]}, 32'h01);
`endif

    BGN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
